// File: rtl/frog_collision_if.sv
// Bus between the lane game core and the collision/lives manager.
// Handshake: o_respawn is held high until i_respawn_ack is sampled high; the request drops on the following edge.
interface frog_collision_if #(
  parameter int NUM_LANES = 4
);
  logic                   i_tick;
  logic [4:0]             i_frog_x;
  logic [4:0]             i_frog_y;
  logic [5*NUM_LANES-1:0] i_car_x;
  logic                   i_respawn_ack;
  logic                   i_restart;
  logic                   o_hit;
  logic [2:0]             o_lives;
  logic                   o_respawn;
  logic                   o_game_over;

  modport master (
    output i_tick, i_frog_x, i_frog_y, i_car_x, i_respawn_ack, i_restart,
    input  o_hit, o_lives, o_respawn, o_game_over
  );

  modport slave (
    input  i_tick, i_frog_x, i_frog_y, i_car_x, i_respawn_ack, i_restart,
    output o_hit, o_lives, o_respawn, o_game_over
  );
endinterface

// File: rtl/frog_collision.sv
// Frame-synchronous collision scan, lives counter, respawn handshake, grace
// period and game-over state for the lane game.
module frog_collision #(
  parameter int          NUM_LANES    = 4,
  parameter logic [4:0]  LANE_Y0      = 5'd1,
  parameter int          GRID_W       = 20,
  parameter int          CAR_LEN      = 2,
  parameter int          LIVES        = 3,
  parameter logic [23:0] GRACE_CYCLES = 24'd12500000
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  frog_collision_if.slave  bus,
  output logic [2:0]       o_state
);

  localparam logic [2:0] PLAY  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] HIT   = 3'd2;
  localparam logic [2:0] GRACE = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  localparam int IDX_W = $clog2(NUM_LANES + 1);

  logic [2:0]             state;
  logic [IDX_W-1:0]       lane_idx;
  logic                   sticky;
  logic [23:0]            grace_cnt;
  logic [4:0]             snap_fx;
  logic [4:0]             snap_fy;
  logic [5*NUM_LANES-1:0] snap_car;
  logic                   lane_hit;

  assign o_state = state;

  // d is the forward distance from the car head to the frog, modulo the grid.
  function automatic logic lane_match(input logic [4:0] fx, input logic [4:0] fy,
                                      input logic [4:0] cx, input int k);
    logic [5:0] d;
    if (fx >= cx) d = {1'b0, fx} - {1'b0, cx};
    else          d = {1'b0, fx} + 6'(GRID_W) - {1'b0, cx};
    return (fy == LANE_Y0 + 5'(k)) && ({1'b0, cx} < 6'(GRID_W)) && (d < 6'(CAR_LEN));
  endfunction

  always_comb begin
    lane_hit = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_idx == IDX_W'(k)) lane_hit = lane_match(snap_fx, snap_fy, snap_car[5*k +: 5], k);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state           <= PLAY;
      lane_idx        <= '0;
      sticky          <= 1'b0;
      grace_cnt       <= '0;
      snap_fx         <= '0;
      snap_fy         <= '0;
      snap_car        <= '0;
      bus.o_hit       <= 1'b0;
      bus.o_lives     <= 3'(LIVES);
      bus.o_respawn   <= 1'b0;
      bus.o_game_over <= 1'b0;
    end else begin
      bus.o_hit <= 1'b0;
      case (state)
        PLAY: begin
          if (bus.i_tick) begin
            snap_fx  <= bus.i_frog_x;
            snap_fy  <= bus.i_frog_y;
            snap_car <= bus.i_car_x;
            lane_idx <= '0;
            sticky   <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          // Index NUM_LANES is the resolve step, one clock after the last lane.
          if (lane_idx == IDX_W'(NUM_LANES)) begin
            if (sticky) begin
              bus.o_hit <= 1'b1;
              if (bus.o_lives != 3'd0) bus.o_lives <= bus.o_lives - 3'd1;
              if (bus.o_lives <= 3'd1) begin
                bus.o_game_over <= 1'b1;
                state           <= OVER;
              end else begin
                bus.o_respawn <= 1'b1;
                state         <= HIT;
              end
            end else begin
              state <= PLAY;
            end
          end else begin
            sticky   <= sticky | lane_hit;
            lane_idx <= lane_idx + 1'b1;
          end
        end
        HIT: begin
          if (bus.i_respawn_ack) begin
            bus.o_respawn <= 1'b0;
            grace_cnt     <= GRACE_CYCLES;
            state         <= GRACE;
          end
        end
        GRACE: begin
          if (grace_cnt == 24'd0) state <= PLAY;
          else                    grace_cnt <= grace_cnt - 24'd1;
        end
        OVER: begin
          if (bus.i_restart) begin
            bus.o_lives     <= 3'(LIVES);
            bus.o_game_over <= 1'b0;
            state           <= PLAY;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_frog_collision.sv
// Scoreboard bench for frog_collision: scans, wrap/range edges, handshake, grace, game over, async reset.
module tb_frog_collision;

  localparam logic [2:0] PLAY  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] HIT   = 3'd2;
  localparam logic [2:0] GRACE = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  logic       clk;
  logic       rst_n;
  logic [2:0] st;

  frog_collision_if #(.NUM_LANES(4)) bus ();

  frog_collision #(
    .NUM_LANES(4), .LANE_Y0(5'd1), .GRID_W(20), .CAR_LEN(2), .LIVES(3),
    .GRACE_CYCLES(24'd10)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus), .o_state(st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int         n_cmp = 0;
  int         n_err = 0;
  int         model_lives;
  logic [2:0] exp_state;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] cars4(input logic [4:0] c0, input logic [4:0] c1,
                                        input logic [4:0] c2, input logic [4:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic bit model_hit(input logic [4:0] fx, input logic [4:0] fy, input logic [19:0] cars);
    int cx;
    for (int k = 0; k < 4; k++) begin
      cx = int'(cars[5*k +: 5]);
      if (int'(fy) == 1 + k && cx < 20 && ((int'(fx) + 20 - cx) % 20) < 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  // drivers
  task automatic run_scan(input logic [4:0] fx, input logic [4:0] fy,
                          input logic [19:0] cars, input bit corrupt);
    bit         eh;
    int         el;
    logic [3:0] e;
    @(negedge clk);
    bus.i_frog_x = fx;
    bus.i_frog_y = fy;
    bus.i_car_x  = cars;
    bus.i_tick   = 1'b1;
    eh = model_hit(fx, fy, cars);
    el = eh ? model_lives - 1 : model_lives;
    exp_q.push_back({eh, 3'(el)});
    @(posedge clk);
    #1;
    bus.i_tick = 1'b0;
    if (corrupt) begin
      bus.i_frog_x = 5'd15;
      bus.i_frog_y = 5'd3;
      bus.i_car_x  = cars4(5'd0, 5'd0, 5'd0, 5'd0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("hit_early", bus.o_hit, 1'b0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("hit", bus.o_hit, e[3]);
    check("lives", bus.o_lives, e[2:0]);
    if (!e[3])              exp_state = PLAY;
    else if (e[2:0] == 3'd0) exp_state = OVER;
    else                    exp_state = HIT;
    check("scan_state", st, exp_state);
    check("respawn_rise", bus.o_respawn, exp_state == HIT);
    check("game_over", bus.o_game_over, exp_state == OVER);
    model_lives = el;
    @(posedge clk);
    #1;
    check("hit_pulse", bus.o_hit, 1'b0);
  endtask

  task automatic ack_grace(input int hold, input bit test_grace);
    repeat (hold) @(posedge clk);
    #1;
    check("respawn_hold", bus.o_respawn, 1'b1);
    @(negedge clk);
    bus.i_respawn_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.i_respawn_ack = 1'b0;
    check("respawn_fall", bus.o_respawn, 1'b0);
    check("grace_entry", st, GRACE);
    if (test_grace) begin
      bus.i_frog_x = 5'd6;
      bus.i_frog_y = 5'd1;
      bus.i_car_x  = cars4(5'd5, 5'd10, 5'd10, 5'd10);
      bus.i_tick   = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("grace_nohit", bus.o_hit, 1'b0);
      check("grace_state", st, GRACE);
    end
    bus.i_tick = 1'b0;
    @(posedge clk);
    #1;
    check("grace_exit", st, PLAY);
    exp_state = PLAY;
  endtask

  task automatic do_restart();
    @(negedge clk);
    bus.i_restart = 1'b1;
    @(posedge clk);
    #1;
    bus.i_restart = 1'b0;
    check("restart_lives", bus.o_lives, 3'd3);
    check("restart_go", bus.o_game_over, 1'b0);
    check("restart_state", st, PLAY);
    model_lives = 3;
    exp_state   = PLAY;
  endtask

  task automatic check_reset_vals();
    check("rst_lives", bus.o_lives, 3'd3);
    check("rst_hit", bus.o_hit, 1'b0);
    check("rst_respawn", bus.o_respawn, 1'b0);
    check("rst_go", bus.o_game_over, 1'b0);
    check("rst_state", st, PLAY);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.i_tick        = 1'b0;
    bus.i_frog_x      = '0;
    bus.i_frog_y      = '0;
    bus.i_car_x       = '0;
    bus.i_respawn_ack = 1'b0;
    bus.i_restart     = 1'b0;
    model_lives       = 3;
    exp_state         = PLAY;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_vals();

    run_scan(5'd5, 5'd1, cars4(5'd7, 5'd10, 5'd10, 5'd10), 1'b0);
    run_scan(5'd5, 5'd1, cars4(5'd25, 5'd10, 5'd10, 5'd10), 1'b0);
    run_scan(5'd6, 5'd1, cars4(5'd5, 5'd10, 5'd10, 5'd10), 1'b0);
    ack_grace(20, 1'b1);
    run_scan(5'd6, 5'd1, cars4(5'd5, 5'd10, 5'd10, 5'd10), 1'b0);
    ack_grace(0, 1'b0);
    run_scan(5'd0, 5'd2, cars4(5'd10, 5'd19, 5'd10, 5'd10), 1'b0);

    // game over ignores tick and ack
    @(negedge clk);
    bus.i_tick        = 1'b1;
    bus.i_respawn_ack = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("over_hit", bus.o_hit, 1'b0);
    check("over_lives", bus.o_lives, 3'd0);
    check("over_state", st, OVER);
    check("over_respawn", bus.o_respawn, 1'b0);
    bus.i_tick        = 1'b0;
    bus.i_respawn_ack = 1'b0;
    do_restart();

    // snapshot isolation, then async reset while in HIT
    run_scan(5'd6, 5'd1, cars4(5'd5, 5'd10, 5'd10, 5'd10), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n       = 1'b1;
    model_lives = 3;
    exp_q.delete();

    // async reset mid-scan
    @(negedge clk);
    bus.i_frog_x = 5'd6;
    bus.i_frog_y = 5'd1;
    bus.i_car_x  = cars4(5'd5, 5'd10, 5'd10, 5'd10);
    bus.i_tick   = 1'b1;
    @(posedge clk);
    #1;
    bus.i_tick = 1'b0;
    check("scan_running", st, SCAN);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // last-lane hit after reset
    run_scan(5'd3, 5'd4, cars4(5'd10, 5'd10, 5'd10, 5'd2), 1'b0);
    ack_grace(0, 1'b0);

    // random scans
    for (int i = 0; i < 12; i++) begin
      run_scan(5'($urandom_range(0, 19)), 5'($urandom_range(1, 4)),
               cars4(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))), 1'b0);
      if (exp_state == HIT)       ack_grace(0, 1'b0);
      else if (exp_state == OVER) do_restart();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frog_collision.md
# frog_collision

Frame-synchronous collision and lives manager for the lane game. Once per game tick it snapshots the frog position and every lane's car X position (the 5-bit positions produced by the lane car movers), scans the lanes one per clock, and reports a hit when the frog cell overlaps a car span. It owns the lives counter, the respawn handshake toward the frog controller, a post-hit grace period, and the game-over state.

## Interface
- NUM_LANES, 4, number of car lanes; lane k occupies grid row LANE_Y0+k
- LANE_Y0, 5'd1, grid row of lane 0
- GRID_W, 20, grid width in cells; valid X is 0..GRID_W-1
- CAR_LEN, 2, car length in cells, extending toward +X with wrap
- LIVES, 3, lives loaded at reset and restart (1..7)
- GRACE_CYCLES, 24'd12500000, clocks of collision immunity after respawn
- i_Clk  input  1  system clock
- i_Rst_n  input  1  reset, asynchronous assert, active-low
- i_tick  input  1  one-cycle frame strobe that starts a scan
- i_frog_x  input  5  frog column
- i_frog_y  input  5  frog row
- i_car_x  input  5*NUM_LANES  packed car X; lane k at bits [5k+4:5k]
- i_respawn_ack  input  1  frog controller has moved frog to start
- i_restart  input  1  leave game-over, reload lives
- o_hit  output  1  one-cycle pulse on detected collision
- o_lives  output  3  remaining lives
- o_respawn  output  1  respawn request, held until acknowledged
- o_game_over  output  1  level, high while in OVER

## Operation
- States: PLAY, SCAN, HIT, GRACE, OVER. Reset enters PLAY with o_lives=LIVES, o_hit=0, o_respawn=0, o_game_over=0, grace counter 0, lane index 0.
- PLAY: on i_tick, register i_frog_x, i_frog_y and all of i_car_x into a snapshot, then go to SCAN with lane index 0. Without i_tick, stay in PLAY.
- SCAN: evaluate one lane per clock, index 0..NUM_LANES-1, using snapshot values only. Input changes during the scan have no effect. i_tick is ignored while scanning.
- Lane k hits when all of these hold:
  - frog_y == LANE_Y0+k
  - car_x < GRID_W; an out-of-range car_x disables that lane
  - d < CAR_LEN, where d = frog_x-car_x if frog_x>=car_x, else frog_x+GRID_W-car_x
- The d computation is at least 6 bits wide, with no truncation.
- Any hit is latched into a sticky flag for the rest of the scan. After lane NUM_LANES-1:
  - No hit: return to PLAY.
  - Hit: pulse o_hit for one clock and decrement o_lives. If the new value is 0, go to OVER. Otherwise go to HIT.
- HIT: hold o_respawn=1. When i_respawn_ack is sampled high, drop o_respawn on the next clock, load the grace counter with GRACE_CYCLES, and go to GRACE. Holding ack high before the request is accepted the same way.
- GRACE: decrement the counter every clock and ignore i_tick. Go to PLAY in the clock after the counter reaches 0. If GRACE_CYCLES=0, GRACE lasts one clock.
- OVER: hold o_game_over=1 and o_lives=0, and ignore i_tick and i_respawn_ack. On i_restart, reload o_lives=LIVES, clear o_game_over and go to PLAY. i_restart is ignored in every other state.
- o_lives never underflows; a decrement at 0 cannot occur.
- Reset assertion mid-scan, mid-handshake or mid-grace immediately forces the reset values. No partial scan result survives.

## Timing
- All outputs are registered and change only on the rising edge of i_Clk, except on asynchronous reset.
- Tick sampled at edge T. The snapshot is valid after T. Lanes are evaluated at edges T+1..T+NUM_LANES.
- o_hit is high during the cycle after edge T+NUM_LANES+1. o_lives updates on that same edge.
- Scan latency from tick to hit is NUM_LANES+1 clocks. A tick arriving in the cycle o_hit or PLAY re-entry is registered is accepted only if the state is PLAY at that edge.
- o_respawn rises on the same edge as o_hit (HIT entry). It falls one edge after ack is sampled.
- o_game_over rises on the same edge as o_hit for the final life.

## Test plan
- Miss: frog (5,1), lane0 car_x=7, CAR_LEN=2, tick -> no o_hit after 5 clocks, o_lives stays 3, state returns to PLAY.
- Direct hit and wrap hit:
  - Frog (6,1), lane0 car_x=5 -> o_hit one cycle at tick+5 edges, o_lives=2, o_respawn=1.
  - Frog (0,2), lane1 car_x=19 -> hit via wrap, d=1.
- Snapshot isolation: tick with frog (6,1), car_x=5, then change the inputs to a miss one cycle later -> hit still reported. Out-of-range case: car_x=25 on the frog's row -> no hit.
- Handshake and grace (GRACE_CYCLES=10):
  - After a hit, keep ack low for 20 cycles -> o_respawn stays 1.
  - Raise ack -> o_respawn falls next edge.
  - Ticks with a colliding position during the 10 grace clocks -> no o_hit. A tick after grace -> hit.
- Game over: three consecutive hits with acks -> o_lives 3→2→1→0, o_game_over=1, o_respawn stays 0. Ticks are ignored; i_restart -> o_lives=3, o_game_over=0.
- Async reset: assert i_Rst_n low mid-scan and mid-HIT -> all outputs at reset values without a clock edge, and the next tick scans normally.
